// File: rtl/jtgate_line_pkg.sv
// Shared types and default timing constants for the transmission-gate line receiver.
package jtgate_line_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_FILTER_LEN   = 3;
  localparam int HALF_BIT         = DEF_CLKS_PER_BIT / 2;
  localparam int CNT_W            = $clog2(DEF_CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rxState_e;

endpackage

// File: rtl/jtgate_line_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only follows
// the synchronised line once it has differed for FILTER_LEN consecutive cycles.
module jtgate_line_filter
  import jtgate_line_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  localparam int FcW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic           sync1_q;
  logic           sync2_q;
  logic           fl_q;
  logic           fl_d;
  logic [FcW-1:0] stable_q;
  logic [FcW-1:0] stable_d;

  // Idle line is high, so everything resets to 1 to avoid a spurious start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      fl_q     <= 1'b1;
      stable_q <= '0;
    end else begin
      sync1_q  <= d_i;
      sync2_q  <= sync1_q;
      fl_q     <= fl_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    fl_d     = fl_q;
    stable_d = '0;
    if (sync2_q != fl_q) begin
      if (stable_q == FcW'(FILTER_LEN - 1)) begin
        fl_d = sync2_q;
      end else begin
        stable_d = stable_q + FcW'(1);
      end
    end
  end

  assign q_o = fl_q;

endmodule

// File: rtl/jtgate_line_receiver.sv
// Frame decoder for the shared pulled-up single-wire line: start/data/stop
// framing, framing-error and overrun reporting, valid/ready word hand-off.
module jtgate_line_receiver
  import jtgate_line_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FILTER_LEN   = DEF_FILTER_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_i,
  input  logic              rx_en_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int HalfBit = CLKS_PER_BIT / 2;
  localparam int BaudW   = $clog2(CLKS_PER_BIT);
  localparam int BitW    = $clog2(DATA_W + 1);

  logic              fl;
  logic              flPrev_q;
  rxState_e          state_q,    state_d;
  logic [BaudW-1:0]  baudCnt_q,  baudCnt_d;
  logic [BitW-1:0]   bitCnt_q,   bitCnt_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic [DATA_W-1:0] data_q,     data_d;
  logic              valid_q,    valid_d;
  logic              frameErr_q, frameErr_d;
  logic              overrun_q,  overrun_d;
  logic              goodFrame;
  logic              flFall;
  logic              halfDone;
  logic              bitDone;

  jtgate_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) uFilter (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (line_i),
    .q_o  (fl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flPrev_q   <= 1'b1;
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      flPrev_q   <= fl;
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign flFall   = flPrev_q & ~fl;
  assign halfDone = (baudCnt_q == BaudW'(HalfBit - 1));
  assign bitDone  = (baudCnt_q == BaudW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    baudCnt_d  = baudCnt_q + BaudW'(1);
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    frameErr_d = 1'b0;
    goodFrame  = 1'b0;
    case (state_q)
      IDLE: begin
        baudCnt_d = '0;
        if (flFall && rx_en_i) begin
          state_d  = START;
          bitCnt_d = '0;
        end
      end
      START: begin
        if (halfDone) begin
          baudCnt_d = '0;
          state_d   = fl ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bitDone) begin
          baudCnt_d = '0;
          shift_d   = {fl, shift_q[DATA_W-1:1]};
          bitCnt_d  = bitCnt_q + BitW'(1);
          if (bitCnt_q == BitW'(DATA_W - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bitDone) begin
          baudCnt_d = '0;
          if (fl) begin
            goodFrame = 1'b1;
            state_d   = IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = BREAK;
          end
        end
      end
      BREAK: begin
        baudCnt_d = '0;
        if (fl) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disabling the receiver throws away whatever frame is in flight.
    if (!rx_en_i) begin
      state_d    = IDLE;
      baudCnt_d  = '0;
      goodFrame  = 1'b0;
      frameErr_d = 1'b0;
    end
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (goodFrame) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frameErr_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_jtgate_line_receiver.sv
// Scoreboard bench for jtgate_line_receiver: frames are driven through a
// transmission-gate model onto a pulled-up wire, expected words queued at send time.
module tb_jtgate_line_receiver;
  import jtgate_line_pkg::*;

  localparam int DataW   = DEF_DATA_W;
  localparam int Cpb     = DEF_CLKS_PER_BIT;
  localparam int FiltLen = DEF_FILTER_LEN;

  logic clk = 1'b0;
  logic rst_n;
  logic rxEn;
  logic readyMan;
  logic randReady;
  logic randBit = 1'b0;
  logic gateEn;
  logic gateData;
  wire  line;
  wire  readyI;

  logic [DataW-1:0] dataO;
  logic             validO;
  logic             frameErrO;
  logic             overrunO;
  logic             busyO;

  // Transmission gate: drives the wire only when enabled, otherwise the pull-up wins.
  assign line = gateEn ? gateData : 1'bz;
  pullup (line);

  assign readyI = randReady ? randBit : readyMan;

  jtgate_line_receiver #(
    .DATA_W      (DataW),
    .CLKS_PER_BIT(Cpb),
    .FILTER_LEN  (FiltLen)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_i     (line),
    .rx_en_i    (rxEn),
    .data_o     (dataO),
    .valid_o    (validO),
    .ready_i    (readyI),
    .frame_err_o(frameErrO),
    .overrun_o  (overrunO),
    .busy_o     (busyO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int startCyc = 0;
  int riseCyc = 0;
  int validCycles = 0;
  int busyCycles = 0;
  int errPulses = 0;
  int ovrPulses = 0;
  int expErr = 0;
  int expOvr = 0;
  logic validPrev = 1'b0;
  logic [DataW-1:0] expQ[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      randBit = 1'($urandom % 2);
    end
  end

  // Monitor: pops the scoreboard on every accepted word and tallies pulses.
  initial begin
    logic [DataW-1:0] expWord;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (validO) validCycles++;
        if (busyO) busyCycles++;
        if (frameErrO) errPulses++;
        if (overrunO) ovrPulses++;
        if (validO && !validPrev) riseCyc = cyc;
        validPrev = validO;
        if (validO && readyI) begin
          if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected word: got 0x%0h, expected no word", dataO);
          end else begin
            expWord = expQ.pop_front();
            checkOutput("scoreboard word", 32'(dataO), 32'(expWord));
          end
        end
      end else begin
        validPrev = 1'b0;
      end
    end
  end

  // Sends one frame LSB first; abortBit >= 0 kills the frame in that bit,
  // either by dropping rx_en or (byReset) by pulsing reset.
  task automatic applyStimulus(input logic [DataW-1:0] d, input logic stopBit,
                               input int abortBit, input logic byReset);
    logic v;
    if (abortBit < 0) begin
      if (stopBit) begin
        if (expQ.size() > 0 && !randReady && !readyMan) expOvr++;
        else expQ.push_back(d);
      end else begin
        expErr++;
      end
    end
    startCyc = cyc;
    for (int i = 0; i < DataW + 2; i++) begin
      if (i == 0) v = 1'b0;
      else if (i == DataW + 1) v = stopBit;
      else v = d[i-1];
      gateEn   = 1'b1;
      gateData = v;
      if (i == abortBit && byReset) begin
        tick(Cpb / 4);
        checkOutput("busy before reset", 32'(busyO), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset data_o", 32'(dataO), 32'd0);
        checkOutput("reset valid_o", 32'(validO), 32'd0);
        checkOutput("reset busy_o", 32'(busyO), 32'd0);
        checkOutput("reset pulses", 32'({frameErrO, overrunO}), 32'd0);
        expQ.delete();
        tick(Cpb / 4);
        rst_n = 1'b1;
        tick(Cpb / 2);
      end else if (i == abortBit) begin
        tick(Cpb / 2);
        rxEn = 1'b0;
        tick(1);
        checkOutput("abort busy_o", 32'(busyO), 32'd0);
        tick(Cpb / 2 - 1);
      end else begin
        tick(Cpb);
      end
    end
    if (stopBit) gateEn = 1'b0;
    rxEn = 1'b1;
  endtask

  initial begin
    int v0, b0, e0, o0;
    logic [DataW-1:0] rd;
    logic rs;
    rst_n     = 1'b0;
    rxEn      = 1'b1;
    readyMan  = 1'b1;
    randReady = 1'b0;
    gateEn    = 1'b0;
    gateData  = 1'b1;
    tick(3);
    checkOutput("in-reset data_o", 32'(dataO), 32'd0);
    checkOutput("in-reset valid_o", 32'(validO), 32'd0);
    checkOutput("in-reset busy_o", 32'(busyO), 32'd0);
    checkOutput("in-reset pulses", 32'({frameErrO, overrunO}), 32'd0);
    rst_n = 1'b1;
    tick(2 * Cpb);

    $display("[TB] good frame");
    v0 = validCycles; e0 = errPulses; o0 = ovrPulses;
    applyStimulus(8'hA5, 1'b1, -1, 1'b0);
    tick(Cpb);
    checkOutput("good latency", 32'(riseCyc - startCyc), 32'(9 * Cpb + HALF_BIT + 1 + 2 + FiltLen));
    checkOutput("good valid width", 32'(validCycles - v0), 32'd1);
    checkOutput("good no pulses", 32'((errPulses - e0) + (ovrPulses - o0)), 32'd0);

    $display("[TB] backpressure");
    readyMan = 1'b0;
    applyStimulus(8'h3C, 1'b1, -1, 1'b0);
    tick(Cpb);
    checkOutput("bp valid held", 32'(validO), 32'd1);
    checkOutput("bp data", 32'(dataO), 32'h3C);
    o0 = ovrPulses;
    applyStimulus(8'hFF, 1'b1, -1, 1'b0);
    tick(Cpb);
    checkOutput("bp data kept", 32'(dataO), 32'h3C);
    checkOutput("bp overrun once", 32'(ovrPulses - o0), 32'd1);
    readyMan = 1'b1;
    tick(1);
    checkOutput("bp valid dropped", 32'(validO), 32'd0);
    tick(Cpb);

    $display("[TB] framing error");
    v0 = validCycles; e0 = errPulses;
    applyStimulus(8'h55, 1'b0, -1, 1'b0);
    tick(3 * Cpb);
    checkOutput("ferr busy held", 32'(busyO), 32'd1);
    checkOutput("ferr no valid", 32'(validCycles - v0), 32'd0);
    checkOutput("ferr pulse once", 32'(errPulses - e0), 32'd1);
    gateEn = 1'b0;
    tick(2 * FiltLen + 6);
    checkOutput("ferr busy released", 32'(busyO), 32'd0);
    tick(Cpb);

    $display("[TB] glitches");
    b0 = busyCycles;
    gateEn = 1'b1; gateData = 1'b0;
    tick(2);
    gateEn = 1'b0;
    tick(20);
    checkOutput("glitch ignored", 32'(busyCycles - b0), 32'd0);
    b0 = busyCycles; e0 = errPulses; v0 = validCycles;
    gateEn = 1'b1; gateData = 1'b0;
    tick(HALF_BIT - 1);
    gateEn = 1'b0;
    tick(3 * Cpb);
    checkOutput("false start entered", 32'((busyCycles - b0) > 0), 32'd1);
    checkOutput("false start idle", 32'(busyO), 32'd0);
    checkOutput("false start quiet", 32'((errPulses - e0) + (validCycles - v0)), 32'd0);

    $display("[TB] abort");
    v0 = validCycles;
    applyStimulus(8'hE7, 1'b1, 4, 1'b0);
    tick(2 * Cpb);
    checkOutput("abort no valid", 32'(validCycles - v0), 32'd0);
    b0 = busyCycles;
    rxEn = 1'b0;
    gateEn = 1'b1; gateData = 1'b0;
    tick(20);
    rxEn = 1'b1;
    tick(20);
    gateEn = 1'b0;
    tick(20);
    checkOutput("reenable while low", 32'(busyCycles - b0), 32'd0);
    applyStimulus(8'h81, 1'b1, -1, 1'b0);
    tick(Cpb);

    $display("[TB] reset mid-stop");
    readyMan = 1'b0;
    applyStimulus(8'h99, 1'b1, -1, 1'b0);
    tick(Cpb);
    checkOutput("pending before reset", 32'(validO), 32'd1);
    applyStimulus(8'h42, 1'b1, DataW + 1, 1'b1);
    readyMan = 1'b1;
    tick(Cpb);
    applyStimulus(8'h0F, 1'b1, -1, 1'b0);
    tick(Cpb);
    b0 = busyCycles; v0 = validCycles;
    tick(100);
    checkOutput("floating busy", 32'(busyCycles - b0), 32'd0);
    checkOutput("floating valid", 32'(validCycles - v0), 32'd0);

    $display("[TB] random frames");
    randReady = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rd = DataW'($urandom);
      rs = ($urandom % 5) != 0;
      applyStimulus(rd, rs, -1, 1'b0);
      if (!rs) tick(Cpb / 2);
      gateEn = 1'b0;
      tick(Cpb + int'($urandom % Cpb));
    end
    randReady = 1'b0;
    readyMan  = 1'b1;
    tick(4 * Cpb);

    checkOutput("frame error total", 32'(errPulses), 32'(expErr));
    checkOutput("overrun total", 32'(ovrPulses), 32'(expOvr));
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
